// File: rtl/mbus_read_requester.sv
// rtl/mbus_read_requester.sv - MBus single-phase quadword read initiator
// Drives adr/rq/start, tracks per-word ACKN/VALID, returns words, reports timeout/protocol errors.
module mbus_read_requester #(
    parameter int TIMEOUT = 63,
    parameter int CNTW    = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [14:35] reqAdr,
    input  logic [0:3]   reqRq,
    output logic         busy,
    output logic         wordValid,
    output logic [35:0]  wordData,
    output logic [14:35] wordAdr,
    output logic         parErr,
    output logic         done,
    output logic         timeout,
    output logic         protoErr,
    output logic [14:35] adr,
    output logic         adrHold,
    output logic [0:3]   rq,
    output logic         start,
    input  logic         ackn,
    input  logic         validIn,
    input  logic [35:0]  dIn,
    input  logic         parIn
);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t          state, state_nxt;
    logic [14:35]    base;
    logic [0:3]      mask, ack_pend, val_pend;
    logic [0:3]      ack_pend_nxt, val_pend_nxt;
    logic [1:0]      ack_ptr, val_ptr;
    logic [CNTW-1:0] cnt;
    logic            active, ack_ok, val_ok, act, all_clear, to_hit;

    // First offset at or after p (mod 4) whose mask bit is set.
    function automatic logic [1:0] first_at(input logic [0:3] m, input logic [1:0] p);
        logic [1:0] r;
        logic [1:0] idx;
        r = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        active       = (state != IDLE);
        ack_ok       = active && ackn && (ack_pend != 4'b0);
        val_ok       = active && validIn && (val_pend != 4'b0);
        act          = ackn || validIn;
        ack_pend_nxt = ack_pend;
        val_pend_nxt = val_pend;
        if (ack_ok) ack_pend_nxt[ack_ptr] = 1'b0;
        if (val_ok) val_pend_nxt[val_ptr] = 1'b0;
        all_clear    = (ack_pend_nxt == 4'b0) && (val_pend_nxt == 4'b0);
        to_hit       = !act && (cnt == CNTW'(TIMEOUT));
        busy         = active;
        start        = (state == REQ);
        adrHold      = (state == REQ);
        adr          = (state == REQ) ? base : '0;
        rq           = (state == REQ) ? mask : '0;
        case (state)
            IDLE:      if (req && reqRq != 4'b0) state_nxt = REQ;
            REQ, XFER: begin
                if (all_clear || to_hit)       state_nxt = IDLE;
                else if (state == REQ && ack_ok) state_nxt = XFER;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base      <= '0;
            mask      <= '0;
            ack_pend  <= '0;
            val_pend  <= '0;
            ack_ptr   <= '0;
            val_ptr   <= '0;
            cnt       <= '0;
            wordValid <= 1'b0;
            wordData  <= '0;
            wordAdr   <= '0;
            parErr    <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            protoErr  <= 1'b0;
        end else begin
            wordValid <= 1'b0;
            parErr    <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            protoErr  <= 1'b0;
            if (!active) begin
                if (act) protoErr <= 1'b1;
                if (req) begin
                    if (reqRq != 4'b0) begin
                        base     <= reqAdr;
                        mask     <= reqRq;
                        ack_pend <= reqRq;
                        val_pend <= reqRq;
                        ack_ptr  <= first_at(reqRq, reqAdr[34:35]);
                        val_ptr  <= first_at(reqRq, reqAdr[34:35]);
                        cnt      <= '0;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else begin
                if (ack_ok) begin
                    ack_pend <= ack_pend_nxt;
                    ack_ptr  <= first_at(mask, ack_ptr + 2'd1);
                end else if (ackn) begin
                    protoErr <= 1'b1;
                end
                if (val_ok) begin
                    val_pend  <= val_pend_nxt;
                    val_ptr   <= first_at(mask, val_ptr + 2'd1);
                    wordValid <= 1'b1;
                    wordData  <= dIn;
                    wordAdr   <= {base[14:33], val_ptr};
                    parErr    <= (parIn != ^dIn);
                end else if (validIn) begin
                    protoErr <= 1'b1;
                end
                if (act || to_hit) cnt <= '0;
                else               cnt <= cnt + CNTW'(1);
                if (all_clear) begin
                    done <= 1'b1;
                end else if (to_hit) begin
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mbus_read_requester.sv
// tb/tb_mbus_read_requester.sv - directed self-checking bench for mbus_read_requester
module tb_mbus_read_requester;

    logic         clk = 1'b0;
    logic         reset;
    logic         req;
    logic [14:35] reqAdr;
    logic [0:3]   reqRq;
    logic         busy, wordValid, parErr, done, timeout, protoErr, adrHold, start;
    logic [35:0]  wordData;
    logic [14:35] wordAdr, adr;
    logic [0:3]   rq;
    logic         ackn, validIn, parIn;
    logic [35:0]  dIn;

    mbus_read_requester #(.TIMEOUT(63), .CNTW(6)) dut (
        .clk(clk), .reset(reset), .req(req), .reqAdr(reqAdr), .reqRq(reqRq),
        .busy(busy), .wordValid(wordValid), .wordData(wordData), .wordAdr(wordAdr),
        .parErr(parErr), .done(done), .timeout(timeout), .protoErr(protoErr),
        .adr(adr), .adrHold(adrHold), .rq(rq), .start(start),
        .ackn(ackn), .validIn(validIn), .dIn(dIn), .parIn(parIn)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [21:0] ev_adr[$];
    logic [35:0] ev_dat[$];
    logic        ev_par[$];
    int n_done, n_proto, n_to, done_ev;
    logic done_wv;
    logic [35:0] dat [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        ev_adr.delete(); ev_dat.delete(); ev_par.delete();
        n_done = 0; n_proto = 0; n_to = 0; done_ev = -1; done_wv = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (wordValid) begin
            ev_adr.push_back(wordAdr);
            ev_dat.push_back(wordData);
            ev_par.push_back(parErr);
        end
        if (done) begin
            n_done++;
            done_ev = ev_adr.size();
            done_wv = wordValid;
        end
        if (protoErr) n_proto++;
        if (timeout)  n_to++;
    endtask

    task automatic chk_ev(input string tag, input int i, input logic [21:0] ea,
                          input logic [35:0] ed, input logic ep);
        check({tag, "_adr"}, (i < ev_adr.size()) ? ev_adr[i] : 22'bx, ea);
        check({tag, "_dat"}, (i < ev_dat.size()) ? ev_dat[i] : 36'bx, ed);
        check({tag, "_par"}, (i < ev_par.size()) ? ev_par[i] : 1'bx, ep);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] exp_a [4];
        logic [35:0] d;
        int n_start;
        bit seen;
        dat[0] = 36'o123456701234; dat[1] = 36'o765432107654;
        dat[2] = 36'o000000000001; dat[3] = 36'o777777777777;
        reset = 1'b1; req = 0; reqAdr = '0; reqRq = '0;
        ackn = 0; validIn = 0; dIn = '0; parIn = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_start", start, 0);
        check("rst_adrhold", adrHold, 0);
        check("rst_wv", wordValid, 0);
        check("rst_done", done, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // quadword starting at offset 2, acks first then valids
        clear();
        reqAdr = 22'o1002; reqRq = 4'b1111; req = 1; step(); req = 0;
        check("s1_busy", busy, 1);
        check("s1_start", start, 1);
        check("s1_adrhold", adrHold, 1);
        check("s1_adr", adr, 22'o1002);
        check("s1_rq", rq, 4'b1111);
        ackn = 1; step();
        check("s1_start_drop", start, 0);
        check("s1_adrhold_drop", adrHold, 0);
        step(); step(); step(); ackn = 0;
        for (int i = 0; i < 4; i++) begin
            validIn = 1; dIn = dat[i]; parIn = ^dat[i]; step();
        end
        validIn = 0; step();
        exp_a[0] = 22'o1002; exp_a[1] = 22'o1003; exp_a[2] = 22'o1000; exp_a[3] = 22'o1001;
        check("s1_nwords", ev_adr.size(), 4);
        for (int i = 0; i < 4; i++) chk_ev("s1_w", i, exp_a[i], dat[i], 1'b0);
        check("s1_ndone", n_done, 1);
        check("s1_done_ev", done_ev, 4);
        check("s1_done_wv", done_wv, 1);
        check("s1_busy_end", busy, 0);
        check("s1_proto", n_proto, 0);

        // sparse mask 0101, extra ackn
        clear();
        reqAdr = 22'o2001; reqRq = 4'b0101; req = 1; step(); req = 0;
        check("s2_rq", rq, 4'b0101);
        ackn = 1; step(); step();
        check("s2_proto_pre", n_proto, 0);
        step(); ackn = 0;
        check("s2_proto", n_proto, 1);
        check("s2_busy_mid", busy, 1);
        validIn = 1; dIn = dat[0]; parIn = ^dat[0]; step();
        dIn = dat[1]; parIn = ^dat[1]; step(); validIn = 0; step();
        check("s2_nwords", ev_adr.size(), 2);
        chk_ev("s2_w0", 0, 22'o2001, dat[0], 1'b0);
        chk_ev("s2_w1", 1, 22'o2003, dat[1], 1'b0);
        check("s2_ndone", n_done, 1);
        check("s2_done_ev", done_ev, 2);
        check("s2_proto_end", n_proto, 1);

        // single word with bad parity
        clear();
        d = 36'o123456654321;
        reqAdr = 22'o10002; reqRq = 4'b0010; req = 1; step(); req = 0;
        ackn = 1; step(); ackn = 0;
        validIn = 1; dIn = d; parIn = ~(^d); step(); validIn = 0;
        check("s3_wv", wordValid, 1);
        check("s3_par", parErr, 1);
        check("s3_adr", wordAdr, 22'o10002);
        check("s3_dat", wordData, d);
        check("s3_done", done, 1);
        step();
        check("s3_busy", busy, 0);

        // timeout: no ackn ever
        clear();
        reqAdr = 22'o100; reqRq = 4'b1000; req = 1; step(); req = 0;
        n_start = start ? 1 : 0;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            step();
            if (timeout) begin
                seen = 1;
                check("s4_to_done", done, 1);
                check("s4_to_start", start, 0);
                check("s4_to_busy", busy, 0);
            end else if (start) n_start++;
        end
        check("s4_seen", seen, 1);
        check("s4_start_cycles", n_start, 64);
        step();
        check("s4_to_pulse", timeout, 0);
        check("s4_nto", n_to, 1);

        // zero mask request and ackn while idle
        clear();
        reqAdr = 22'o5; reqRq = 4'b0000; req = 1; step(); req = 0;
        check("s5_done", done, 1);
        check("s5_busy", busy, 0);
        check("s5_start", start, 0);
        ackn = 1; step(); ackn = 0;
        check("s5_idle_proto", protoErr, 1);
        check("s5_busy2", busy, 0);

        // simultaneous ackn+validIn, then back-to-back, then reset mid-transfer
        clear();
        reqAdr = 22'o3000; reqRq = 4'b1111; req = 1; step(); req = 0;
        for (int i = 0; i < 4; i++) begin
            ackn = 1; validIn = 1; dIn = dat[i]; parIn = ^dat[i]; step();
        end
        ackn = 0; validIn = 0;
        check("s6_nwords", ev_adr.size(), 4);
        for (int i = 0; i < 4; i++) chk_ev("s6_w", i, 22'o3000 + 22'(i), dat[i], 1'b0);
        check("s6_proto", n_proto, 0);
        check("s6_done_ev", done_ev, 4);
        reqAdr = 22'o4000; reqRq = 4'b1111; req = 1; step(); req = 0;
        check("s6_b2b_busy", busy, 1);
        check("s6_b2b_adr", adr, 22'o4000);
        ackn = 1; validIn = 1; dIn = dat[0]; parIn = ^dat[0]; step();
        ackn = 0; validIn = 0;
        check("s6_mid_wv", wordValid, 1);
        #2 reset = 1;
        #1;
        check("s6_rst_wv", wordValid, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_start", start, 0);
        check("s6_rst_adr", adr, 0);
        check("s6_rst_data", wordData, 0);
        clear();
        step(); step();
        reset = 0;
        step(); step();
        check("s6_rst_ndone", n_done, 0);
        check("s6_rst_busy_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mbus_read_requester.md
Name: mbus_read_requester

Overview:
- Initiator (controller) end of the single-phase MBus read protocol; drives one memory phase as the counterpart of a core-memory responder.
- Accepts a quadword read request from the cache/MBox side and drives adr/adrHold/rq/start.
- Tracks per-word ACKN and VALID, returns each word with its address and parity status, and signals completion.
- Reports timeout and protocol errors.

Parameters:
- TIMEOUT, 63, cycles without any ackn/validIn activity in an active state before the transfer aborts.
- CNTW, 6, width of the timeout counter; must satisfy 2**CNTW > TIMEOUT.

Ports:
- clk  input  1  MBus phase clock; all logic on posedge.
- reset  input  1  asynchronous, active-high.
- req  input  1  request strobe; sampled only when busy=0.
- reqAdr  input  22 [14:35]  word address of the first word.
- reqRq  input  4 [0:3]  rq[n]=1 requests word n of the quadword.
- busy  output  1  request in progress.
- wordValid  output  1  one-cycle pulse; wordData/wordAdr/parErr valid.
- wordData  output  36  returned word.
- wordAdr  output  22 [14:35]  address of the returned word.
- parErr  output  1  qualifies wordValid; parity mismatch.
- done  output  1  one-cycle completion pulse.
- timeout  output  1  one-cycle pulse, coincident with done on abort.
- protoErr  output  1  one-cycle pulse on an unexpected ackn or validIn.
- adr  output  22 [14:35]  MBus address.
- adrHold  output  1  address valid; memory latches while high.
- rq  output  4 [0:3]  MBus request bits.
- start  output  1  MBus START.
- ackn  input  1  memory word acknowledge.
- validIn  input  1  memory data valid.
- dIn  input  36  memory data.
- parIn  input  1  memory parity; correct when parIn == ^dIn.

Behaviour:
- Reset: all outputs 0; state IDLE; pending masks, pointers and timeout counter cleared. Reset mid-transfer aborts with no done pulse.
- States: IDLE, REQ, XFER.
- IDLE:
  - req=1 with reqRq!=0: latch base=reqAdr, mask=reqRq; ackPend=valPend=mask; ackPtr=valPtr=reqAdr[34:35]. Next state REQ.
  - req=1 with reqRq==0: done pulses the next cycle; no bus activity.
- REQ:
  - start=1, adrHold=1, adr=base, rq=mask, all registered (first asserted the cycle after acceptance).
  - First ackn sampled: next state XFER; start and adrHold drop the following cycle.
- Pointer rule: ackPtr/valPtr hold the word offset of the next expected word. Sequence starts at base[34:35] and increments mod 4, skipping offsets whose mask bit is 0.
- ackn (REQ or XFER): clear ackPend[ackPtr]; advance ackPtr.
- validIn (REQ or XFER): capture dIn and parIn; clear valPend[valPtr]; advance valPtr.
  - Next cycle: wordValid=1, wordData=captured data, wordAdr={base[14:33], offset}, parErr=(parIn != ^dIn).
  - Latency: 1 cycle from validIn to wordValid.
- Overlap: validIn may precede remaining acks. ackn and validIn in the same cycle are both processed.
- Completion: when ackPend==0 and valPend==0, done pulses one cycle (the same cycle as the last wordValid) and the state returns to IDLE. busy drops with done.
- protoErr: ackn with ackPend==0, validIn with valPend==0, or either input in IDLE. Pulse protoErr; otherwise ignore the event.
- validIn while its word is unacked is accepted; memory may VALID before the matching ACKN is seen.
- Timeout:
  - Counter clears on acceptance and on any ackn or validIn; increments otherwise in REQ/XFER.
  - When count==TIMEOUT: timeout=1 and done=1 in the same cycle; start and adrHold drop; state returns to IDLE.
- busy=1 in REQ and XFER. req while busy is ignored, not queued.
- Back-to-back: a new req in the first IDLE cycle after done is accepted.

Test Plan:
- reqAdr=0o1002, reqRq=1111; memory acks 4 words in consecutive cycles, then VALIDs 4 words -> 4 wordValid pulses with wordAdr 0o1002, 0o1003, 0o1000, 0o1001; done on the 4th; start high until the cycle after the 1st ackn.
- reqAdr=0o2001, reqRq=0101 -> exactly 2 words, addresses 0o2001 then 0o2003; a 3rd ackn pulses protoErr with no other effect.
- Single word rq=0010 at 0o10002; dIn=0o123456654321 with parIn inverted -> wordValid with parErr=1; done in the same cycle.
- No ackn after start -> timeout and done at TIMEOUT=63 idle cycles; start=0 the next cycle; busy=0.
- Simultaneous ackn+validIn each cycle for 4 words -> 4 wordValid pulses 1 cycle later, no protoErr; reset asserted mid-transfer -> all outputs 0 immediately, no done pulse.
